// File: rtl/pipelined_carry_select_addsub.sv
// pipelined_carry_select_addsub
// Two's-complement add/subtract split across STAGES registered stages. Each stage
// sums a run of SEG_W-bit segments (ripple for segment 0, carry-select elsewhere)
// and hands its carry to the next stage, under valid/ready flow control.
// Optional macro ODE_ADDSUB_SATURATE_EN clamps overflowing results to the signed limits.
module pipelined_carry_select_addsub #(
   parameter int WIDTH  = 20,
   parameter int SEG_W  = 2,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             v,
   output logic             zero
);

   localparam int NSEG = WIDTH / SEG_W;
   localparam int SPS  = (NSEG + STAGES - 1) / STAGES;

   logic [STAGES-1:0] valid_q, valid_d;
   logic [STAGES-1:0] carry_q, carry_d;
   logic [STAGES-1:0] advance;
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  a_d [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  b_d [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [WIDTH-1:0]  s_d [STAGES];
   logic              v_q, v_d;
   logic              zero_q, zero_d;

   // A stage may move forward if it, or any stage after it, is empty, or the consumer takes the result
   always_comb begin
      logic full;
      full    = 1'b1;
      advance = '0;
      for (int k = 0; k < STAGES; k++) begin
         full = 1'b1;
         for (int j = k; j < STAGES; j++) begin
            full = full & valid_q[j];
         end
         advance[k] = ~full | out_ready;
      end
   end

   assign in_ready = ~rst & advance[0];

   // Per-stage arithmetic: pick up the stage inputs, sum this stage's segments, compute flags at the end
   always_comb begin
      logic             stg_v;
      logic             stg_c;
      logic             ov;
      logic [WIDTH-1:0] stg_a;
      logic [WIDTH-1:0] stg_b;
      logic [WIDTH-1:0] stg_s;
      logic [WIDTH-1:0] fin_s;
      logic [SEG_W-1:0] seg_a;
      logic [SEG_W-1:0] seg_b;
      logic [SEG_W:0]   r0;
      logic [SEG_W:0]   r1;
      int               prev;

      valid_d = valid_q;
      carry_d = carry_q;
      v_d     = v_q;
      zero_d  = zero_q;
      for (int k = 0; k < STAGES; k++) begin
         a_d[k] = a_q[k];
         b_d[k] = b_q[k];
         s_d[k] = s_q[k];
      end
      stg_v = 1'b0;
      stg_c = 1'b0;
      ov    = 1'b0;
      stg_a = '0;
      stg_b = '0;
      stg_s = '0;
      fin_s = '0;
      seg_a = '0;
      seg_b = '0;
      r0    = '0;
      r1    = '0;
      prev  = 0;

      for (int k = 0; k < STAGES; k++) begin
         prev = (k > 0) ? k - 1 : 0;
         if (k == 0) begin
            stg_v = in_valid & in_ready;
            stg_a = in0;
            stg_b = sub ? ~in1 : in1;
            stg_s = '0;
            stg_c = cin | sub;
         end else begin
            stg_v = valid_q[prev];
            stg_a = a_q[prev];
            stg_b = b_q[prev];
            stg_s = s_q[prev];
            stg_c = carry_q[prev];
         end

         for (int g = 0; g < NSEG; g++) begin
            if (g >= k * SPS && g < (k + 1) * SPS) begin
               if (g == 0) begin
                  for (int i = 0; i < SEG_W; i++) begin
                     stg_s[i] = stg_a[i] ^ stg_b[i] ^ stg_c;
                     stg_c    = (stg_a[i] & stg_b[i]) | (stg_c & (stg_a[i] ^ stg_b[i]));
                  end
               end else begin
                  seg_a = stg_a[g*SEG_W +: SEG_W];
                  seg_b = stg_b[g*SEG_W +: SEG_W];
                  r0    = {1'b0, seg_a} + {1'b0, seg_b};
                  r1    = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG_W{1'b0}}, 1'b1};
                  stg_s[g*SEG_W +: SEG_W] = stg_c ? r1[SEG_W-1:0] : r0[SEG_W-1:0];
                  stg_c = stg_c ? r1[SEG_W] : r0[SEG_W];
               end
            end
         end

         ov = (stg_a[WIDTH-1] & stg_b[WIDTH-1] & ~stg_s[WIDTH-1]) |
              (~stg_a[WIDTH-1] & ~stg_b[WIDTH-1] & stg_s[WIDTH-1]);
`ifdef ODE_ADDSUB_SATURATE_EN
         fin_s = ov ? (stg_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}}) : stg_s;
`else
         fin_s = stg_s;
`endif

         if (advance[k]) begin
            valid_d[k] = stg_v;
            if (stg_v) begin
               a_d[k]     = stg_a;
               b_d[k]     = stg_b;
               s_d[k]     = (k == STAGES - 1) ? fin_s : stg_s;
               carry_d[k] = stg_c;
               if (k == STAGES - 1) begin
                  v_d    = ov;
                  zero_d = (fin_s == '0);
               end
            end
         end
      end
   end

   // Pipeline registers; synchronous reset empties every stage and clears the result
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         carry_q <= '0;
         v_q     <= 1'b0;
         zero_q  <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
      end else begin
         valid_q <= valid_d;
         carry_q <= carry_d;
         v_q     <= v_d;
         zero_q  <= zero_d;
         for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
      end
   end

   assign out_valid = valid_q[STAGES-1];
   assign sum       = s_q[STAGES-1];
   assign cout      = carry_q[STAGES-1];
   assign v         = v_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_carry_select_addsub.sv
// tb_pipelined_carry_select_addsub
// Three instances (STAGES = 2, 1, 5) share the input stimulus; each has its own
// scoreboard fed by an arithmetic reference model. Directed cases target the main
// STAGES=2 instance.
module tb_pipelined_carry_select_addsub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        sub;
   logic [19:0] in0;
   logic [19:0] in1;
   logic        cin;
   logic        out_ready;
   logic [2:0]  in_ready_w;
   logic [2:0]  out_valid_w;
   logic [2:0]  cout_w;
   logic [2:0]  v_w;
   logic [2:0]  zero_w;
   logic [19:0] sum_w [3];

   int total_checks = 0;
   int bad_checks   = 0;

   always #5 clk = ~clk;

   function automatic int cfgStages(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 1 : 5);
   endfunction

   // Reference: true signed/unsigned arithmetic, packed as {cout, v, zero, sum}
   function automatic logic [22:0] refModel(input logic s, input logic [19:0] a, input logic [19:0] b,
                                            input logic c);
      longint      sa;
      longint      sb;
      longint      true_res;
      logic        co;
      logic        ov;
      logic [19:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (s) begin
         true_res = sa - sb;
         co       = (a >= b);
      end else begin
         true_res = sa + sb + longint'(c);
         co       = (longint'(a) + longint'(b) + longint'(c)) > 64'hFFFFF;
      end
      ov  = (true_res > 524287) || (true_res < -524288);
      res = true_res[19:0];
`ifdef ODE_ADDSUB_SATURATE_EN
      if (ov) res = (true_res > 0) ? 20'h7FFFF : 20'h80000;
`endif
      return {co, ov, (res == 20'h0), res};
   endfunction

   function automatic logic [19:0] pickOperand();
      case ($urandom_range(0, 6))
         0:       return 20'h7FFFF;
         1:       return 20'h80000;
         2:       return 20'hFFFFF;
         3:       return 20'h00000;
         default: return 20'($urandom);
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_checks++;
      if (got !== exp) begin
         bad_checks++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one operation and hold it until the main instance accepts it
   task automatic applyStimulus(input logic s, input logic [19:0] a, input logic [19:0] b, input logic c);
      int wait_cycles;
      wait_cycles = 0;
      in_valid = 1'b1;
      sub      = s;
      in0      = a;
      in1      = b;
      cin      = c;
      @(negedge clk);
      while (!in_ready_w[0] && wait_cycles < 50) begin
         @(negedge clk);
         wait_cycles++;
      end
      if (!in_ready_w[0]) checkOutput("accept_timeout", 32'(in_ready_w[0]), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input string tag, input logic [19:0] exp_sum, input logic exp_cout,
                             input logic exp_v, input logic exp_zero);
      int cycles;
      cycles = 0;
      @(negedge clk);
      while (!out_valid_w[0] && cycles < 20) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput({tag, "_valid"}, 32'(out_valid_w[0]), 32'd1);
      checkOutput({tag, "_sum"},   32'(sum_w[0]),       32'(exp_sum));
      checkOutput({tag, "_cout"},  32'(cout_w[0]),      32'(exp_cout));
      checkOutput({tag, "_v"},     32'(v_w[0]),         32'(exp_v));
      checkOutput({tag, "_zero"},  32'(zero_w[0]),      32'(exp_zero));
      @(posedge clk);
      #1;
   endtask

   for (genvar i = 0; i < 3; i++) begin : g_dut
      logic [22:0] exp_q [$];
      logic [22:0] head;

      pipelined_carry_select_addsub #(
         .WIDTH (20),
         .SEG_W (2),
         .STAGES(i == 0 ? 2 : (i == 1 ? 1 : 5))
      ) dut (
         .clk      (clk),
         .rst      (rst),
         .in_valid (in_valid),
         .in_ready (in_ready_w[i]),
         .sub      (sub),
         .in0      (in0),
         .in1      (in1),
         .cin      (cin),
         .out_valid(out_valid_w[i]),
         .out_ready(out_ready),
         .sum      (sum_w[i]),
         .cout     (cout_w[i]),
         .v        (v_w[i]),
         .zero     (zero_w[i])
      );

      // Scoreboard: record accepted operations, compare each emitted result in order
      always @(negedge clk) begin
         if (rst) begin
            exp_q.delete();
         end else begin
            if (out_valid_w[i] && out_ready) begin
               if (exp_q.size() == 0) begin
                  checkOutput($sformatf("extra_out_%0d", i), 32'(out_valid_w[i]), 32'd0);
               end else begin
                  head = exp_q.pop_front();
                  checkOutput($sformatf("result_%0d", i),
                              {9'd0, cout_w[i], v_w[i], zero_w[i], sum_w[i]}, {9'd0, head});
               end
            end
            if (in_valid && in_ready_w[i]) exp_q.push_back(refModel(sub, in0, in1, cin));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [19:0] bp_a [6];
      logic [19:0] bp_b [6];
      logic        bp_s [6];
      logic        bp_c [6];
      logic [22:0] bp_first;

      rst       = 1'b1;
      in_valid  = 1'b0;
      sub       = 1'b0;
      in0       = '0;
      in1       = '0;
      cin       = 1'b0;
      out_ready = 1'b1;

      // Reset state
      @(posedge clk);
      @(negedge clk);
      checkOutput("in_ready_in_reset", 32'(in_ready_w), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("in_ready_after_reset", 32'(in_ready_w), 32'd7);
      checkOutput("out_valid_reset", 32'(out_valid_w), 32'd0);
      checkOutput("cout_reset", 32'(cout_w), 32'd0);
      checkOutput("v_reset", 32'(v_w), 32'd0);
      checkOutput("zero_reset", 32'(zero_w), 32'd0);
      for (int i = 0; i < 3; i++) checkOutput($sformatf("sum_reset_%0d", i), 32'(sum_w[i]), 32'd0);
      @(posedge clk);
      #1;

      // Latency of every instance on a lone add
      applyStimulus(1'b0, 20'h00003, 20'h00005, 1'b1);
      for (int n = 1; n <= 5; n++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("latency_%0d_cyc%0d", i, n), 32'(out_valid_w[i]),
                        32'(n == cfgStages(i)));
         end
         if (n == 2) begin
            checkOutput("add_sum", 32'(sum_w[0]), 32'h00009);
            checkOutput("add_cout", 32'(cout_w[0]), 32'd0);
            checkOutput("add_v", 32'(v_w[0]), 32'd0);
            checkOutput("add_zero", 32'(zero_w[0]), 32'd0);
         end
      end
      @(posedge clk);
      #1;

      // Directed arithmetic cases
      applyStimulus(1'b1, 20'h00005, 20'h00007, 1'b0);
      waitResult("sub_borrow", 20'hFFFFE, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 20'h00007, 20'h00007, 1'b0);
      waitResult("sub_equal", 20'h00000, 1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 20'hFFFFF, 20'h00001, 1'b0);
      waitResult("full_chain", 20'h00000, 1'b1, 1'b0, 1'b1);
`ifdef ODE_ADDSUB_SATURATE_EN
      applyStimulus(1'b0, 20'h7FFFF, 20'h00001, 1'b0);
      waitResult("ovf_pos", 20'h7FFFF, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 20'h80000, 20'h00001, 1'b0);
      waitResult("ovf_neg", 20'h80000, 1'b1, 1'b1, 1'b0);
`else
      applyStimulus(1'b0, 20'h7FFFF, 20'h00001, 1'b0);
      waitResult("ovf_pos", 20'h80000, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 20'h80000, 20'h00001, 1'b0);
      waitResult("ovf_neg", 20'h7FFFF, 1'b1, 1'b1, 1'b0);
`endif

      // Backpressure: six back-to-back ops against a stalled consumer
      for (int k = 0; k < 6; k++) begin
         bp_a[k] = pickOperand();
         bp_b[k] = pickOperand();
         bp_s[k] = 1'($urandom);
         bp_c[k] = 1'($urandom);
      end
      bp_first  = refModel(bp_s[0], bp_a[0], bp_b[0], bp_c[0]);
      out_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) applyStimulus(bp_s[k], bp_a[k], bp_b[k], bp_c[k]);
         end
         begin
            repeat (2) @(negedge clk);
            for (int n = 0; n < 4; n++) begin
               @(negedge clk);
               checkOutput("bp_in_ready", 32'(in_ready_w[0]), 32'd0);
               checkOutput("bp_out_valid", 32'(out_valid_w[0]), 32'd1);
               checkOutput("bp_hold", {9'd0, cout_w[0], v_w[0], zero_w[0], sum_w[0]}, {9'd0, bp_first});
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join
      repeat (20) @(posedge clk);
      #1;

      // Reset with two operations in flight
      out_ready = 1'b0;
      applyStimulus(1'b0, 20'h11111, 20'h22222, 1'b0);
      applyStimulus(1'b1, 20'h33333, 20'h01234, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("in_ready_midreset", 32'(in_ready_w), 32'd0);
      @(posedge clk);
      #1;
      rst       = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      checkOutput("midreset_out_valid", 32'(out_valid_w), 32'd0);
      checkOutput("midreset_sum", 32'(sum_w[0]), 32'd0);
      checkOutput("midreset_flags", {29'd0, cout_w[0], v_w[0], zero_w[0]}, 32'd0);
      checkOutput("midreset_in_ready", 32'(in_ready_w), 32'd7);
      for (int n = 0; n < 5; n++) begin
         @(negedge clk);
         checkOutput("midreset_no_emit", 32'(out_valid_w), 32'd0);
      end
      @(posedge clk);
      #1;
      applyStimulus(1'b0, 20'h12345, 20'h00111, 1'b0);
      @(negedge clk);
      checkOutput("post_reset_early", 32'(out_valid_w[0]), 32'd0);
      @(negedge clk);
      checkOutput("post_reset_valid", 32'(out_valid_w[0]), 32'd1);
      checkOutput("post_reset_sum", 32'(sum_w[0]), 32'h12456);
      @(posedge clk);
      #1;

      // Random traffic with random backpressure
      for (int n = 0; n < 400; n++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         sub       = 1'($urandom);
         cin       = 1'($urandom);
         in0       = pickOperand();
         in1       = pickOperand();
         out_ready = ($urandom_range(0, 2) != 0);
         @(posedge clk);
         #1;
      end

      // Drain and confirm every accepted operation came out
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (20) @(posedge clk);
      @(negedge clk);
      checkOutput("drain_q0", 32'(g_dut[0].exp_q.size()), 32'd0);
      checkOutput("drain_q1", 32'(g_dut[1].exp_q.size()), 32'd0);
      checkOutput("drain_q2", 32'(g_dut[2].exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule

// File: doc/pipelined_carry_select_addsub.md
Name: pipelined_carry_select_addsub

Overview:
- Parametrised, pipelined successor to the team's fixed 20-bit carry-select add/subtract unit.
- Width, segment size and pipeline depth are generic. Operands are accepted through a valid/ready handshake at a sustained rate of one operation per cycle.
- Used by the ODE solver datapath wherever a registered add/sub with signed-overflow detection is needed at clock rates the flat combinational carry chain cannot meet.

Parameters:
- WIDTH, 20, operand/result width in bits; must be a multiple of SEG_W.
- SEG_W, 2, carry-select segment width. Segment 0 is a ripple adder; all other segments are carry-select.
- STAGES, 2, pipeline depth, 1..WIDTH/SEG_W. Stage k handles segments k*ceil(NSEG/STAGES) onward, where NSEG=WIDTH/SEG_W; the last stage may hold fewer segments.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operand transfer request
- in_ready  output  1  block can accept operands this cycle
- sub  input  1  1 = subtract (in0 - in1), 0 = add
- in0  input  WIDTH  operand A, two's complement
- in1  input  WIDTH  operand B, two's complement
- cin  input  1  carry in (add mode only)
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB
- v  output  1  signed overflow
- zero  output  1  sum == 0 (after saturation, if enabled)

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Operand conditioning, applied at capture:
  - effective B = sub ? ~in1 : in1
  - effective carry-in = cin | sub, so sub=1 forces a carry-in of 1 regardless of cin.
- Transfers: an input transfer occurs on a clk edge with in_valid && in_ready; an output transfer occurs with out_valid && out_ready.
- Pipeline structure:
  - Each stage holds a valid bit, the inter-stage carry, the already-summed low bits, the not-yet-summed high operand bits, and sub/sign info for the overflow calculation.
  - Within a stage, segments chain their carries combinationally: ripple for segment 0, carry-select elsewhere.
  - The carry out of a stage's last segment is registered as the carry-in of the next stage's first segment.
- Latency and throughput: exactly STAGES cycles from input transfer to out_valid when never stalled; throughput is one operation per cycle.
- Flow control:
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when it is empty or out_ready=1.
  - in_ready = stage 0 can advance (combinational from out_ready through the valid chain).
  - No bubbles are inserted when full and out_ready=1.
- Hold: while out_valid && !out_ready, sum/cout/v/zero/out_valid hold stable. in_ready falls once all STAGES entries are occupied.
- Ordering and integrity: in order; no loss or duplication under any handshake pattern.
- Flag equations:
  - v = (A[MSB] & B'[MSB] & ~s[MSB]) | (~A[MSB] & ~B'[MSB] & s[MSB]), where B' is the effective B and s is the raw sum.
  - cout is the raw carry out of the MSB, so in sub mode cout=1 means no borrow.
- Reset:
  - All valid bits clear; out_valid=0, sum=0, cout=0, v=0, zero=0 (zero is registered, not derived from the reset sum).
  - in_ready=0 during the reset cycle and 1 from the following cycle.
  - Reset mid-operation discards all in-flight operations.
- Edge cases:
  - in_valid=0: no state change except draining.
  - Simultaneous input and output transfers when full are legal.
  - STAGES=1 gives a single registered output stage.

Optional Feature:
- Macro: ODE_ADDSUB_SATURATE_EN.
- Defined: when v=1, sum clamps to the maximum positive value (0 followed by ones) if A[MSB]=0, else to the minimum negative value (1 followed by zeros). v and cout still report the raw result; zero is computed on the clamped value.
- Undefined: sum wraps modulo 2^WIDTH; no clamp logic is generated.

Test Plan (WIDTH=20, SEG_W=2, STAGES=2 unless noted):
- Add: in0=0x00003, in1=0x00005, sub=0, cin=1 -> after 2 cycles sum=0x00009, cout=0, v=0, zero=0.
- Subtract with borrow: in0=0x00005, in1=0x00007, sub=1, cin=0 -> sum=0xFFFFE, cout=0, v=0. Then in0=0x00007, in1=0x00007 -> sum=0, cout=1, zero=1.
- Full carry chain across every segment and stage: 0xFFFFF + 0x00001 -> sum=0x00000, cout=1, v=0, zero=1.
- Overflow:
  - 0x7FFFF + 0x00001 -> v=1, sum=0x80000 (0x7FFFF with ODE_ADDSUB_SATURATE_EN).
  - 0x80000 - 0x00001 -> v=1, sum=0x7FFFF (0x80000 saturated).
- Backpressure: stream 6 back-to-back ops, hold out_ready=0 for 4 cycles -> in_ready=0 once 2 entries are held; outputs stable while stalled; all 6 results emerge in order with no duplicates. Repeat with STAGES=1 and STAGES=5.
- Reset mid-stream: assert rst for 1 cycle with 2 ops in flight -> out_valid=0, all outputs 0 next cycle; neither op is ever emitted; a new op issued after reset completes in 2 cycles.
